// File: rtl/mips32_mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port 1024x32 memory.
// One access is in flight at a time: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP.
module mips32_mem_arbiter #(
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   // instruction-fetch port (read-only)
   input  logic        if_req,
   input  logic [9:0]  if_addr,
   output logic        if_gnt,
   output logic [31:0] if_rdata,
   output logic        if_rvalid,
   input  logic        if_flush,
   // data port
   input  logic        d_req,
   input  logic        d_we,
   input  logic [9:0]  d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic [31:0] d_rdata,
   output logic        d_rvalid,
   // memory side
   output logic        mem_en,
   output logic        mem_we,
   output logic [9:0]  mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [2:0] LAT_LAST   = 3'(MEM_LAT - 1);
   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

   state_t      state_q, state_d;
   logic        win_d_q, win_d_d;        // 1: data port owns the transaction
   logic        we_q, we_d;
   logic [9:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  wait_cnt_q, wait_cnt_d;
   logic [2:0]  starve_q, starve_d;
   logic        cancel_q, cancel_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        fetch_wins;

   always_comb begin
      state_d    = state_q;
      win_d_d    = win_d_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wait_cnt_d = wait_cnt_q;
      starve_d   = starve_q;
      cancel_d   = cancel_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      fetch_wins = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      if_gnt     = 1'b0;
      d_gnt      = 1'b0;
      if_rvalid  = 1'b0;
      d_rvalid   = 1'b0;

      case (state_q)
         IDLE: begin
            cancel_d = 1'b0;
            if (if_req || d_req) begin
               // data has priority unless fetch has lost STARVE_MAX contested rounds
               fetch_wins = if_req && (!d_req || (starve_q == STARVE_LIM));
               state_d    = ISSUE;
               win_d_d    = !fetch_wins;
               addr_d     = fetch_wins ? if_addr : d_addr;
               we_d       = !fetch_wins && d_we;
               if (!fetch_wins) begin
                  wdata_d = d_wdata;
               end
               if (fetch_wins) begin
                  starve_d = 3'd0;
               end else if (if_req && (starve_q < STARVE_LIM)) begin
                  starve_d = starve_q + 3'd1;
               end
            end
         end

         ISSUE: begin
            mem_en     = 1'b1;
            mem_we     = we_q;
            if_gnt     = !win_d_q;
            d_gnt      = win_d_q;
            wait_cnt_d = 3'd0;
            state_d    = WAIT;
            if (!win_d_q && if_flush) begin
               cancel_d = 1'b1;
            end
         end

         WAIT: begin
            if (!win_d_q && if_flush) begin
               cancel_d = 1'b1;
            end
            if (wait_cnt_q == LAT_LAST) begin
               state_d = RESP;
               // a write acknowledge leaves the data read register untouched
               if (!win_d_q) begin
                  if_rdata_d = mem_rdata;
               end else if (!we_q) begin
                  d_rdata_d = mem_rdata;
               end
            end else begin
               wait_cnt_d = wait_cnt_q + 3'd1;
            end
         end

         RESP: begin
            if_rvalid = !win_d_q && !cancel_q && !if_flush;
            d_rvalid  = win_d_q;
            cancel_d  = 1'b0;
            state_d   = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         win_d_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 10'd0;
         wdata_q    <= 32'd0;
         wait_cnt_q <= 3'd0;
         starve_q   <= 3'd0;
         cancel_q   <= 1'b0;
         if_rdata_q <= 32'd0;
         d_rdata_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         win_d_q    <= win_d_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wait_cnt_q <= wait_cnt_d;
         starve_q   <= starve_d;
         cancel_q   <= cancel_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Bench for mips32_mem_arbiter: three instances (MEM_LAT 1, 3, 4), each with a behavioural memory.
// Instance 0 is checked through a grant/response scoreboard; the others by directed timing checks.
module tb_mips32_mem_arbiter;

   logic        clk;
   logic [2:0]  rst, if_req, if_flush, d_req, d_we;
   logic [9:0]  if_addr [3];
   logic [9:0]  d_addr [3];
   logic [31:0] d_wdata [3];
   logic [2:0]  if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
   logic [31:0] if_rdata [3];
   logic [31:0] d_rdata [3];
   logic [31:0] mem_wdata [3];
   logic [31:0] mem_rdata [3];
   logic [9:0]  mem_addr [3];

   typedef struct packed {
      logic        port;   // 0 = fetch, 1 = data
      logic [31:0] data;
   } rsp_t;

   rsp_t exp_rsp[$];
   logic exp_gnt[$];
   int   total, bad, mon_total, mon_bad;
   logic g_pop;
   rsp_t r_pop;

   function automatic logic [31:0] init_word(int a);
      if (a == 5) return 32'h2A00_0001;
      return 32'h1000_0000 + 32'(a);
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 3 : 4);
      logic [31:0] mem [0:1023];
      logic [31:0] pipe [0:3];
      bit          mem_ready;

      mips32_mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(4)) u_dut (
         .clk(clk), .rst(rst[gi]),
         .if_req(if_req[gi]), .if_addr(if_addr[gi]), .if_gnt(if_gnt[gi]),
         .if_rdata(if_rdata[gi]), .if_rvalid(if_rvalid[gi]), .if_flush(if_flush[gi]),
         .d_req(d_req[gi]), .d_we(d_we[gi]), .d_addr(d_addr[gi]), .d_wdata(d_wdata[gi]),
         .d_gnt(d_gnt[gi]), .d_rdata(d_rdata[gi]), .d_rvalid(d_rvalid[gi]),
         .mem_en(mem_en[gi]), .mem_we(mem_we[gi]), .mem_addr(mem_addr[gi]),
         .mem_wdata(mem_wdata[gi]), .mem_rdata(mem_rdata[gi]), .busy(busy[gi])
      );

      // registered read, then LAT-1 extra pipeline stages
      always @(posedge clk) begin
         if (!mem_ready) begin
            for (int k = 0; k < 1024; k++) mem[k] <= init_word(k);
            mem_ready <= 1'b1;
         end else if (mem_en[gi]) begin
            if (mem_we[gi]) mem[mem_addr[gi]] <= mem_wdata[gi];
            pipe[0] <= mem[mem_addr[gi]];
         end
         for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
      end
      assign mem_rdata[gi] = pipe[LAT-1];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   task automatic wait_idle(int idx, string name);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (busy[idx] && n < 30);
      chk(name, 32'(busy[idx]), 32'd0);
   endtask

   // scoreboard monitor for instance 0
   always @(negedge clk) begin
      if (!rst[0]) begin
         if (if_gnt[0] || d_gnt[0]) begin
            mon_total++;
            if (exp_gnt.size() == 0) begin
               mon_bad++;
               $display("FAIL gnt_order: unexpected grant if_gnt=%0b d_gnt=%0b", if_gnt[0], d_gnt[0]);
            end else begin
               g_pop = exp_gnt.pop_front();
               if (d_gnt[0] !== g_pop || if_gnt[0] !== !g_pop) begin
                  mon_bad++;
                  $display("FAIL gnt_order: got if_gnt=%0b d_gnt=%0b expected %s", if_gnt[0], d_gnt[0], g_pop ? "D" : "F");
               end else begin
                  $display("ok   gnt: %s", g_pop ? "D" : "F");
               end
            end
            if (if_gnt[0]) begin
               mon_total++;
               if (g_dut[0].u_dut.starve_q !== 3'd0) begin
                  mon_bad++;
                  $display("FAIL starve_clear: got %0d expected 0", g_dut[0].u_dut.starve_q);
               end
            end
         end
         if (if_rvalid[0] || d_rvalid[0]) begin
            mon_total++;
            if (exp_rsp.size() == 0) begin
               mon_bad++;
               $display("FAIL rsp: unexpected if_rvalid=%0b d_rvalid=%0b", if_rvalid[0], d_rvalid[0]);
            end else begin
               r_pop = exp_rsp.pop_front();
               if (d_rvalid[0] !== r_pop.port ||
                   (r_pop.port ? d_rdata[0] : if_rdata[0]) !== r_pop.data) begin
                  mon_bad++;
                  $display("FAIL rsp: got port=%s if_rdata=0x%08h d_rdata=0x%08h expected port=%s data=0x%08h",
                           d_rvalid[0] ? "D" : "F", if_rdata[0], d_rdata[0], r_pop.port ? "D" : "F", r_pop.data);
               end else begin
                  $display("ok   rsp: %s 0x%08h", r_pop.port ? "D" : "F", r_pop.data);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n_g, rv_cyc, busy_cnt;
      logic seen;
      total = 0; bad = 0;
      rst = 3'b111; if_req = '0; if_flush = '0; d_req = '0; d_we = '0;
      for (int i = 0; i < 3; i++) begin
         if_addr[i] = '0; d_addr[i] = '0; d_wdata[i] = '0;
      end
      repeat (3) step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_strobes", 32'({mem_en, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid}), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr[0]), 32'd0);
      chk("rst_mem_wdata", mem_wdata[0], 32'd0);
      chk("rst_if_rdata", if_rdata[0], 32'd0);
      chk("rst_d_rdata", d_rdata[0], 32'd0);
      rst = 3'b000;

      // single fetch of word 5
      exp_gnt.push_back(1'b0); exp_rsp.push_back('{1'b0, 32'h2A00_0001});
      if_req[0] = 1'b1; if_addr[0] = 10'd5;
      step();
      chk("fetch_issue_gnt_en", 32'({if_gnt[0], mem_en[0], mem_we[0]}), 32'b110);
      chk("fetch_issue_addr", 32'(mem_addr[0]), 32'd5);
      if_req[0] = 1'b0;
      step();
      chk("fetch_wait_en", 32'(mem_en[0]), 32'd0);
      step();
      chk("fetch_rvalid_c3", 32'(if_rvalid[0]), 32'd1);
      step();
      chk("fetch_busy_c4", 32'(busy[0]), 32'd0);

      // data read of word 9
      exp_gnt.push_back(1'b1); exp_rsp.push_back('{1'b1, 32'h1000_0009});
      d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 10'd9;
      step();
      d_req[0] = 1'b0;
      wait_idle(0, "dread_idle");

      // data write to word 7: acknowledge leaves d_rdata as the previous read
      exp_gnt.push_back(1'b1); exp_rsp.push_back('{1'b1, 32'h1000_0009});
      d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 10'd7; d_wdata[0] = 32'hDEAD_BEEF;
      step();
      chk("write_mem_we", 32'({mem_en[0], mem_we[0]}), 32'b11);
      chk("write_mem_wdata", mem_wdata[0], 32'hDEAD_BEEF);
      d_req[0] = 1'b0; d_we[0] = 1'b0;
      wait_idle(0, "write_idle");

      // fetch back the written word
      exp_gnt.push_back(1'b0); exp_rsp.push_back('{1'b0, 32'hDEAD_BEEF});
      if_req[0] = 1'b1; if_addr[0] = 10'd7;
      step();
      if_req[0] = 1'b0;
      wait_idle(0, "fetch7_idle");

      // both ports held: D,D,D,D,F,D,D,D,D,F
      for (int i = 0; i < 10; i++) begin
         exp_gnt.push_back((i % 5) != 4);
         exp_rsp.push_back(((i % 5) != 4) ? '{1'b1, 32'h1000_0003} : '{1'b0, 32'h1000_0004});
      end
      d_req[0] = 1'b1; d_addr[0] = 10'd3; if_req[0] = 1'b1; if_addr[0] = 10'd4;
      n_g = 0;
      for (int c = 0; c < 200 && n_g < 10; c++) begin
         step();
         if (if_gnt[0] || d_gnt[0]) n_g++;
      end
      d_req[0] = 1'b0; if_req[0] = 1'b0;
      chk("starve_grant_count", 32'(n_g), 32'd10);
      wait_idle(0, "starve_idle");

      // flush during WAIT of a fetch
      exp_gnt.push_back(1'b0);
      if_req[0] = 1'b1; if_addr[0] = 10'd6;
      step();
      if_req[0] = 1'b0;
      step();
      if_flush[0] = 1'b1;
      step();
      if_flush[0] = 1'b0;
      chk("flush_no_rvalid", 32'(if_rvalid[0]), 32'd0);
      chk("flush_rdata", if_rdata[0], 32'h1000_0006);
      step();
      chk("flush_busy", 32'(busy[0]), 32'd0);

      exp_gnt.push_back(1'b0); exp_rsp.push_back('{1'b0, 32'h2A00_0001});
      if_req[0] = 1'b1; if_addr[0] = 10'd5;
      step();
      if_req[0] = 1'b0;
      wait_idle(0, "after_flush_idle");

      // flush is ignored during a data read
      exp_gnt.push_back(1'b1); exp_rsp.push_back('{1'b1, 32'h1000_0009});
      d_req[0] = 1'b1; d_addr[0] = 10'd9;
      step();
      d_req[0] = 1'b0; if_flush[0] = 1'b1;
      wait_idle(0, "dflush_idle");
      if_flush[0] = 1'b0;
      repeat (2) step();
      chk("sb_gnt_empty", 32'(exp_gnt.size()), 32'd0);
      chk("sb_rsp_empty", 32'(exp_rsp.size()), 32'd0);

      // MEM_LAT=3: complete one read, then reset in the second WAIT cycle of the next
      d_req[1] = 1'b1; d_addr[1] = 10'd10;
      step();
      d_req[1] = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         step();
         if (d_rvalid[1]) seen = 1'b1;
      end
      chk("lat3_rvalid_seen", 32'(seen), 32'd1);
      chk("lat3_rdata", d_rdata[1], 32'h1000_000A);
      wait_idle(1, "lat3_idle");
      d_req[1] = 1'b1; d_addr[1] = 10'd11;
      step();
      d_req[1] = 1'b0;
      chk("lat3_gnt", 32'(d_gnt[1]), 32'd1);
      step();
      step();
      rst[1] = 1'b1;
      step();
      rst[1] = 1'b0;
      chk("rst_wait_busy", 32'(busy[1]), 32'd0);
      chk("rst_wait_d_rdata", d_rdata[1], 32'd0);
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (d_rvalid[1] || mem_en[1]) seen = 1'b1;
         step();
      end
      chk("rst_wait_no_rvalid", 32'(seen), 32'd0);

      // MEM_LAT=4: read of word 1023
      d_req[2] = 1'b1; d_addr[2] = 10'd1023;
      step();
      d_req[2] = 1'b0;
      rv_cyc = -1; busy_cnt = 0;
      for (int c = 1; c <= 12; c++) begin
         if (busy[2]) busy_cnt++;
         if (d_rvalid[2] && rv_cyc < 0) rv_cyc = c;
         step();
      end
      chk("lat4_rvalid_cycle", 32'(rv_cyc), 32'd6);
      chk("lat4_busy_cycles", 32'(busy_cnt), 32'd6);
      chk("lat4_rdata", d_rdata[2], 32'h1000_03FF);

      total = total + mon_total;
      bad = bad + mon_bad;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mips32_mem_arbiter.md
MIPS32_MEM_ARBITER -- requirements
Module: mips32_mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, memory read latency in cycles from the mem_en cycle to the mem_rdata valid cycle; legal range 1..4.
REQ-002 SHALL have parameter STARVE_MAX, default 4, the number of consecutive contested losses by fetch before fetch is forced to win; legal range 1..7.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have ports if_req (in, 1), if_addr (in, 10), if_gnt (out, 1), if_rdata (out, 32), if_rvalid (out, 1) and if_flush (in, 1), forming the instruction-fetch port, which is read-only.
REQ-006 SHALL have ports d_req (in, 1), d_we (in, 1), d_addr (in, 10), d_wdata (in, 32), d_gnt (out, 1), d_rdata (out, 32) and d_rvalid (out, 1), forming the data port, which supports read and write.
REQ-007 SHALL have ports mem_en (out, 1), mem_we (out, 1), mem_addr (out, 10), mem_wdata (out, 32) and mem_rdata (in, 32), connecting to the single-port 1024x32 memory.
REQ-008 SHALL have port busy, output, 1, asserted whenever the state is not IDLE.

Function
REQ-009 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP, with the following transitions:
- IDLE -> ISSUE when any request is present at the edge.
- ISSUE -> WAIT unconditionally.
- WAIT -> RESP after MEM_LAT cycles in WAIT.
- RESP -> IDLE unconditionally.
REQ-010 SHALL sample requests only in IDLE; a request already present with the FSM in IDLE is granted at that edge, and a request held through ISSUE/WAIT/RESP is re-arbitrated only on return to IDLE.
REQ-011 SHALL select the winner at the IDLE edge and latch the winner, address, we and wdata into registers.
REQ-012 SHALL, in ISSUE, drive mem_en=1, mem_addr and mem_wdata from the latched values, mem_we=1 only when the data port wins with d_we=1, and pulse the winner's gnt for exactly this one cycle.
REQ-013 SHALL hold mem_en, mem_we, if_gnt and d_gnt at 0 in all states other than ISSUE.
REQ-014 SHALL capture mem_rdata into the winner's rdata register on the last WAIT cycle.
REQ-015 SHALL, in RESP, pulse the winner's rvalid for one cycle, with the following per-transaction behaviour:
- Data write: d_rvalid serves as the write acknowledge and d_rdata is left unchanged.
- Each rdata register holds its value until the next response on that port.
REQ-016 SHALL give a request-to-rvalid latency of MEM_LAT+2 cycles after the sampling edge (rvalid high in cycle N+2+MEM_LAT) and a throughput of one access per MEM_LAT+3 cycles.
REQ-017 SHALL, when only one port requests, grant that port.
REQ-018 SHALL, when both ports request, grant the data port, unless starve_cnt == STARVE_MAX, in which case it grants fetch.
REQ-019 SHALL maintain the 3-bit starve_cnt as follows:
- Increment when data wins while if_req=1.
- Clear when fetch is granted.
- Saturate at STARVE_MAX and never wrap.
REQ-020 SHALL set a cancel flag when if_flush=1 in any of the cycles ISSUE, WAIT or RESP of a fetch transaction; if_rvalid is suppressed in RESP when the flag is set or if_flush=1 in that cycle; the flag clears on entry to IDLE.
REQ-021 SHALL ignore if_flush during data transactions and in IDLE.
REQ-022 SHALL require requesters to hold req, addr, we and wdata stable until gnt; changes before gnt are neither detected nor reported.

Reset
REQ-023 SHALL, on rst=1 at an edge, set the following:
- state=IDLE.
- starve_cnt=0.
- Cancel flag=0.
- All gnt, rvalid, mem_en, mem_we and busy =0.
- mem_addr=0, mem_wdata=0, if_rdata=0, d_rdata=0.
REQ-024 SHALL, when reset occurs mid-transaction, abandon the transaction with no rvalid and no further memory strobe; a write already strobed in ISSUE is not undone.
REQ-025 SHALL take priority for rst over all other inputs; the first request can be sampled at the first edge after rst deasserts.

Verification
REQ-026 SHALL verify a single fetch: memory word 5 = 0x2A000001, MEM_LAT=1, if_req with if_addr=5 at edge 0 -> if_gnt=1 and mem_en=1 with mem_addr=5 in cycle 1, if_rvalid=1 with if_rdata=0x2A000001 in cycle 3, busy=0 in cycle 4.
REQ-027 SHALL verify a data write followed by a fetch of the same address: d_we=1, d_addr=7, d_wdata=0xDEADBEEF, then if_addr=7 -> mem_we=1 in the write's ISSUE cycle, d_rvalid pulse with d_rdata unchanged, subsequent if_rdata=0xDEADBEEF.
REQ-028 SHALL verify starvation: STARVE_MAX=4, if_req and d_req held high continuously -> grant order D,D,D,D,F,D,D,D,D,F; starve_cnt=0 after each F.
REQ-029 SHALL verify a flush: if_flush=1 in the WAIT cycle of a fetch -> if_gnt pulses, if_rvalid stays 0, if_rdata is updated, the next fetch completes normally with if_rvalid=1.
REQ-030 SHALL verify reset in WAIT during a data read: MEM_LAT=3, rst=1 in the second WAIT cycle -> next cycle busy=0 and d_rdata=0, and no d_rvalid ever occurs for that read.
REQ-031 SHALL verify MEM_LAT=4: for a data read of address 1023, d_rvalid=1 exactly 6 cycles after the sampling edge, and busy is high for exactly 6 cycles.
